// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the instruction/data memory
//                arbiter: FSM state encoding and the default ROM/RAM split.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    // Arbiter FSM states: idle, fetch access, data access, response
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_ACC = 2'd1,
        D_ACC  = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Addresses below this boundary are ROM, at or above it are RAM
    localparam logic [31:0] C_ROM_LIMIT_DEFAULT = 32'h1000_0000;

endpackage
`default_nettype wire

// File: rtl/mem_arb_wait_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_wait_cnt
//  Description : Fairness counter for the memory arbiter. Counts consecutive
//                arbitrations lost by instruction fetch, saturating at
//                MAX_WAIT, and clears whenever fetch is granted.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arb_wait_cnt #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic lose_i,     // fetch lost an arbitration this cycle
    input  logic grant_i,    // fetch was granted this cycle
    output logic at_max_o    // count has reached MAX_WAIT
);

    // A zero MAX_WAIT still needs a one-bit counter
    localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] c_max = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] r_count;

    // Saturating count of lost arbitrations, cleared on a fetch grant
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (grant_i) begin
            r_count <= '0;
        end else if (lose_i && (r_count != c_max)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign at_max_o = (r_count == c_max);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-port (instruction fetch / data) arbiter onto one shared
//                memory. Data normally wins; fetch wins once it has lost
//                MAX_WAIT consecutive arbitrations. Each access takes three
//                cycles: IDLE (grant) -> *_ACC (address out) -> RESP (ready).
//                Optional ROM write protection: define MEM_ARB_ROM_WP_EN to
//                suppress stores below ROM_LIMIT and flag them on err_o.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] ROM_LIMIT  = DATA_WIDTH'(C_ROM_LIMIT_DEFAULT),
    parameter int                    MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req_i,
    input  logic [DATA_WIDTH-1:0] if_addr_i,
    output logic                  if_ready_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [DATA_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wdata_i,
    output logic                  d_ready_o,
    output logic [DATA_WIDTH-1:0] d_rdata_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  err_o
);

`ifdef MEM_ARB_ROM_WP_EN
    localparam logic c_wp_en = 1'b1;
`else
    localparam logic c_wp_en = 1'b0;
`endif

    state_t                r_state;
    logic                  r_if_ready;
    logic                  r_d_ready;
    logic                  r_err;
    logic                  r_blocked;     // store in flight was suppressed
    logic                  r_mem_we;
    logic [DATA_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_d_rdata;

    logic                  w_at_max;
    logic                  w_idle;
    logic                  w_pick_if;
    logic                  w_pick_d;
    logic                  w_block;

    assign w_idle    = (r_state == IDLE);
    // Fetch wins when alone, or when it has been starved long enough
    assign w_pick_if = if_req_i & (~d_req_i | w_at_max);
    assign w_pick_d  = d_req_i & ~w_pick_if;
    // Store into ROM space, only meaningful with write protection enabled
    assign w_block   = c_wp_en & d_we_i & (d_addr_i < ROM_LIMIT);

    mem_arb_wait_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_cnt (
        .clk      (clk),
        .reset    (reset),
        .lose_i   (w_idle & if_req_i & w_pick_d),
        .grant_i  (w_idle & w_pick_if),
        .at_max_o (w_at_max)
    );

    // Arbitration FSM; all outputs are registered and default to idle values
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_if_ready  <= 1'b0;
            r_d_ready   <= 1'b0;
            r_err       <= 1'b0;
            r_blocked   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_if_ready  <= 1'b0;
            r_d_ready   <= 1'b0;
            r_err       <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            case (r_state)
                IDLE: begin
                    // Request fields are captured here so later changes on the
                    // request ports cannot disturb the access in flight
                    if (w_pick_if) begin
                        r_state    <= IF_ACC;
                        r_mem_addr <= if_addr_i;
                    end else if (w_pick_d) begin
                        r_state     <= D_ACC;
                        r_mem_addr  <= d_addr_i;
                        r_mem_wdata <= d_wdata_i;
                        r_mem_we    <= d_we_i & ~w_block;
                        r_blocked   <= w_block;
                    end
                end
                IF_ACC: begin
                    r_if_rdata <= mem_rdata_i;
                    r_if_ready <= 1'b1;
                    r_state    <= RESP;
                end
                D_ACC: begin
                    // Read data is captured for stores too; the requester ignores it
                    r_d_rdata <= mem_rdata_i;
                    r_d_ready <= 1'b1;
                    r_err     <= r_blocked;
                    r_blocked <= 1'b0;
                    r_state   <= RESP;
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign if_ready_o  = r_if_ready;
    assign if_rdata_o  = r_if_rdata;
    assign d_ready_o   = r_d_ready;
    assign d_rdata_o   = r_d_rdata;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign err_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter: directed scenarios with
//                literal expectations, then randomized two-port traffic
//                compared every cycle against a transaction-level model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int          DW        = 32;
    localparam int          MAX_WAIT  = 4;
    localparam logic [31:0] ROM_LIMIT = 32'h1000_0000;
`ifdef MEM_ARB_ROM_WP_EN
    localparam bit WP_EN = 1'b1;
`else
    localparam bit WP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req_i;
    logic [DW-1:0] if_addr_i;
    logic          if_ready_o;
    logic [DW-1:0] if_rdata_o;
    logic          d_req_i;
    logic          d_we_i;
    logic [DW-1:0] d_addr_i;
    logic [DW-1:0] d_wdata_i;
    logic          d_ready_o;
    logic [DW-1:0] d_rdata_o;
    logic          mem_we_o;
    logic [DW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i;
    logic          err_o;

    always #5 clk = ~clk;

    // Memory contents as a pure function of the address
    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h0040_0000) return 32'h2008_0005;
        return {a[15:0], a[31:16]} ^ 32'h1234_5678;
    endfunction

    assign mem_rdata_i = mem_model(mem_addr_o);

    mem_arbiter #(
        .DATA_WIDTH (DW),
        .ROM_LIMIT  (ROM_LIMIT),
        .MAX_WAIT   (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_ready_o  (if_ready_o),
        .if_rdata_o  (if_rdata_o),
        .d_req_i     (d_req_i),
        .d_we_i      (d_we_i),
        .d_addr_i    (d_addr_i),
        .d_wdata_i   (d_wdata_i),
        .d_ready_o   (d_ready_o),
        .d_rdata_o   (d_rdata_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .err_o       (err_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // m_phase: cycles since grant (0 = waiting for a grant, 1 = memory
    // access cycle, 2 = response cycle)
    int          m_phase = 0;
    int          m_wait  = 0;
    bit          m_to_d, m_we, m_blocked;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;

    always @(posedge clk) begin
        if (reset) begin
            m_phase    = 0;
            m_wait     = 0;
            m_if_rdata = 0;
            m_d_rdata  = 0;
        end else if (m_phase == 0) begin
            if (d_req_i || if_req_i) begin
                m_to_d = d_req_i && !(if_req_i && m_wait == MAX_WAIT);
                if (!m_to_d) m_wait = 0;
                else if (if_req_i) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
                m_addr    = m_to_d ? d_addr_i : if_addr_i;
                m_wdata   = m_to_d ? d_wdata_i : 32'h0;
                m_we      = m_to_d && d_we_i;
                m_blocked = m_we && WP_EN && (m_addr < ROM_LIMIT);
                m_phase   = 1;
            end
        end else if (m_phase == 1) begin
            if (m_to_d) m_d_rdata = mem_model(m_addr);
            else        m_if_rdata = mem_model(m_addr);
            m_phase = 2;
        end else begin
            m_phase = 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit chk_en = 1'b0;
    bit if_rdy_seen = 1'b0;
    bit d_rdy_seen  = 1'b0;

    always @(negedge clk) begin
        if_rdy_seen = if_ready_o;
        d_rdy_seen  = d_ready_o;
        if (chk_en) begin
            chk("mem_addr",  mem_addr_o,  (m_phase == 1) ? m_addr : 32'h0);
            chk("mem_we",    mem_we_o,    (m_phase == 1) && m_we && !m_blocked);
            chk("mem_wdata", mem_wdata_o, (m_phase == 1) ? m_wdata : 32'h0);
            chk("if_ready",  if_ready_o,  (m_phase == 2) && !m_to_d);
            chk("d_ready",   d_ready_o,   (m_phase == 2) && m_to_d);
            chk("err",       err_o,       (m_phase == 2) && m_to_d && m_blocked);
            chk("if_rdata",  if_rdata_o,  m_if_rdata);
            chk("d_rdata",   d_rdata_o,   m_d_rdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(0, 1) == 0) a[31:28] = 4'h0;
        if (a == 32'h0) a = 32'h4;
        return a;
    endfunction

    // Global time bound
    initial begin
        #1_000_000;
        n_errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        bit          grants[$];
        bit          pat[10];
        int          cnt, cnt2, if_hold, d_hold, max_hold, n_if_done, n_d_done;

        reset = 1'b1;
        if_req_i = 0; if_addr_i = 0;
        d_req_i = 0; d_we_i = 0; d_addr_i = 0; d_wdata_i = 0;
        repeat (3) tick();

        // Reset state
        chk("rst_mem_we",    mem_we_o,    0);
        chk("rst_mem_addr",  mem_addr_o,  0);
        chk("rst_mem_wdata", mem_wdata_o, 0);
        chk("rst_if_ready",  if_ready_o,  0);
        chk("rst_d_ready",   d_ready_o,   0);
        chk("rst_if_rdata",  if_rdata_o,  0);
        chk("rst_d_rdata",   d_rdata_o,   0);
        chk("rst_err",       err_o,       0);
        reset  = 1'b0;
        chk_en = 1'b1;
        tick();

        // Fetch only: grant seen in cycle N, ready in N+2
        if_req_i = 1; if_addr_i = 32'h0040_0000;
        tick();
        chk("f_acc_addr", mem_addr_o, 32'h0040_0000);
        chk("f_acc_rdy",  if_ready_o, 0);
        tick();
        chk("f_rdy",      if_ready_o, 1);
        chk("f_rdata",    if_rdata_o, 32'h2008_0005);
        if_req_i = 0;
        tick();
        chk("f_rdy_once", if_ready_o, 0);

        // RAM store
        d_req_i = 1; d_we_i = 1; d_addr_i = 32'h1001_0000; d_wdata_i = 32'hDEAD_BEEF;
        tick();
        chk("s_we",       mem_we_o,    1);
        chk("s_addr",     mem_addr_o,  32'h1001_0000);
        chk("s_wdata",    mem_wdata_o, 32'hDEAD_BEEF);
        tick();
        chk("s_we_once",  mem_we_o,    0);
        chk("s_rdy",      d_ready_o,   1);
        chk("s_err",      err_o,       0);
        d_req_i = 0; d_we_i = 0;
        tick();
        chk("s_rdy_once", d_ready_o,   0);

        // Both held: D,D,D,D,IF repeating
        pat = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        if_addr_i = 32'h0000_1110; d_addr_i = 32'h3000_0000; d_we_i = 0; d_wdata_i = 32'h5;
        if_req_i = 1; d_req_i = 1;
        for (int i = 0; i < 60 && grants.size() < 10; i++) begin
            tick();
            if (mem_addr_o == 32'h3000_0000) grants.push_back(1'b1);
            else if (mem_addr_o == 32'h0000_1110) grants.push_back(1'b0);
        end
        if_req_i = 0; d_req_i = 0;
        chk("fair_count", grants.size(), 10);
        for (int i = 0; i < 10; i++) begin
            if (i < grants.size()) chk($sformatf("fair_grant%0d", i), grants[i], pat[i]);
        end
        repeat (3) tick();

        // Store into ROM space
        d_req_i = 1; d_we_i = 1; d_addr_i = 32'h0000_0010; d_wdata_i = 32'h1234_ABCD;
        tick();
        chk("rom_we",   mem_we_o,   WP_EN ? 0 : 1);
        chk("rom_addr", mem_addr_o, 32'h0000_0010);
        tick();
        chk("rom_rdy",  d_ready_o,  1);
        chk("rom_err",  err_o,      WP_EN ? 1 : 0);
        d_req_i = 0; d_we_i = 0;
        tick();
        chk("rom_err_once", err_o, 0);

        // Reset during D_ACC aborts the access
        d_req_i = 1; d_we_i = 1; d_addr_i = 32'h2000_0000; d_wdata_i = 32'hCAFE_F00D;
        tick();
        chk("ra_we", mem_we_o, 1);
        reset = 1;
        tick();
        chk("ra_we0",     mem_we_o,    0);
        chk("ra_addr0",   mem_addr_o,  0);
        chk("ra_wdata0",  mem_wdata_o, 0);
        chk("ra_drdy0",   d_ready_o,   0);
        chk("ra_drdata0", d_rdata_o,   0);
        chk("ra_ifrdata0",if_rdata_o,  0);
        chk("ra_err0",    err_o,       0);
        reset = 0; d_req_i = 0; d_we_i = 0;
        cnt = 0;
        repeat (5) begin
            tick();
            if (d_ready_o) cnt++;
        end
        chk("ra_no_rdy", cnt, 0);

        // One-cycle data pulse while a fetch is in flight
        if_req_i = 1; if_addr_i = 32'h0050_0000;
        tick();
        d_req_i = 1; d_we_i = 0; d_addr_i = 32'h7000_0000;
        tick();
        d_req_i = 0;
        chk("pulse_if_rdy", if_ready_o, 1);
        tick();
        if_req_i = 0;
        cnt = 0; cnt2 = 0;
        repeat (6) begin
            if (d_ready_o) cnt++;
            if (mem_addr_o == 32'h7000_0000) cnt2++;
            tick();
        end
        chk("pulse_no_rdy",   cnt,  0);
        chk("pulse_no_grant", cnt2, 0);

        // Randomized two-port traffic
        if_hold = 0; d_hold = 0; max_hold = 0; n_if_done = 0; n_d_done = 0;
        for (int c = 0; c < 2000; c++) begin
            tick();
            if (if_req_i && if_rdy_seen) begin if_req_i = 0; n_if_done++; end
            if (d_req_i && d_rdy_seen) begin d_req_i = 0; n_d_done++; end
            if (if_req_i && if_hold > 40) if_req_i = 0;
            if (d_req_i && d_hold > 40) d_req_i = 0;
            if (!if_req_i && $urandom_range(0, 2) == 0) begin
                if_req_i = 1; if_addr_i = rand_addr(); if_hold = 0;
            end
            if (!d_req_i && $urandom_range(0, 2) == 0) begin
                d_req_i = 1; d_we_i = $urandom_range(0, 1) == 1;
                d_addr_i = rand_addr(); d_wdata_i = $urandom; d_hold = 0;
            end
            if (if_req_i) if_hold++;
            if (d_req_i) d_hold++;
            if (if_hold > max_hold) max_hold = if_hold;
            if (d_hold > max_hold) max_hold = d_hold;
        end
        if_req_i = 0; d_req_i = 0;
        repeat (4) tick();
        chk("rand_hold_bound", max_hold <= 40, 1);
        chk("rand_if_done",    n_if_done > 50, 1);
        chk("rand_d_done",     n_d_done > 50,  1);

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of address and data buses.
REQ-002 SHALL have parameter ROM_LIMIT, default 32'h1000_0000; addresses below it map to ROM, at or above it map to RAM.
REQ-003 SHALL have parameter MAX_WAIT, default 4, number of consecutive lost arbitrations after which fetch wins.
REQ-004 SHALL have ports, one per line:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- if_req_i  in  1  instruction-fetch request, held until if_ready_o.
- if_addr_i  in  DATA_WIDTH  fetch address, stable while if_req_i.
- if_ready_o  out  1  one-cycle completion pulse for fetch.
- if_rdata_o  out  DATA_WIDTH  fetched word, valid when if_ready_o.
- d_req_i  in  1  data request, held until d_ready_o.
- d_we_i  in  1  1 = store, 0 = load.
- d_addr_i  in  DATA_WIDTH  data address.
- d_wdata_i  in  DATA_WIDTH  store data.
- d_ready_o  out  1  one-cycle completion pulse for data.
- d_rdata_o  out  DATA_WIDTH  load word, valid when d_ready_o.
- mem_we_o  out  1  write enable to the shared memory system.
- mem_addr_o  out  DATA_WIDTH  address to the shared memory system.
- mem_wdata_o  out  DATA_WIDTH  write data to the shared memory system.
- mem_rdata_i  in  DATA_WIDTH  combinational read data from the shared memory system.
- err_o  out  1  write-protect violation pulse.

Function
REQ-005 SHALL implement FSM states IDLE, IF_ACC, D_ACC, RESP.
REQ-006 IDLE SHALL sample requests: only d_req_i -> D_ACC; only if_req_i -> IF_ACC; neither -> stay in IDLE.
REQ-007 With both requests in IDLE, data SHALL win unless the wait counter equals MAX_WAIT, in which case fetch SHALL win.
REQ-008 The wait counter SHALL increment, saturating at MAX_WAIT, when fetch loses an arbitration; it SHALL clear when fetch is granted.
REQ-009 In IF_ACC/D_ACC, mem_addr_o SHALL carry the granted address; mem_rdata_i SHALL be registered at the end of that cycle.
REQ-010 mem_we_o SHALL be 1 only in D_ACC with d_we_i=1, for exactly one cycle; mem_wdata_o SHALL equal d_wdata_i then.
REQ-011 IF_ACC/D_ACC SHALL always go to RESP; RESP SHALL pulse the granted port's ready for one cycle, then return to IDLE.
REQ-012 Latency SHALL be request seen in IDLE at cycle N -> ready at cycle N+2; peak throughput SHALL be one access per 3 cycles.
REQ-013 For a store, the read-data register SHALL still update; the requester ignores it.
REQ-014 rdata outputs SHALL hold their last value between accesses.
REQ-015 Requests that drop before grant SHALL be ignored; requests that change in ACC/RESP SHALL not affect the access in flight.
REQ-016 Outside IF_ACC/D_ACC, mem_addr_o and mem_wdata_o SHALL be 0.

Reset
REQ-017 On reset, state SHALL be IDLE and the wait counter 0.
REQ-018 On reset, all outputs SHALL be 0, including mem_we_o, both ready signals, both rdata outputs and err_o.
REQ-019 Reset asserted mid-access SHALL abort the access with no ready pulse; mem_we_o SHALL be 0 from the next edge.

Configuration
REQ-020 Macro MEM_ARB_ROM_WP_EN defined: a store with d_addr_i < ROM_LIMIT SHALL keep mem_we_o at 0 and pulse err_o together with d_ready_o.
REQ-021 Macro MEM_ARB_ROM_WP_EN undefined: err_o SHALL be tied to 0 and all stores SHALL be forwarded unchanged.

Structure
REQ-022 A shared package SHALL hold the FSM state enum and the ROM_LIMIT default constant.
REQ-023 The fairness counter SHALL be sub-module mem_arb_wait_cnt; all other logic stays in mem_arbiter.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Fetch only, if_addr_i=0x0040_0000, mem_rdata_i=0x2008_0005 -> if_ready_o at N+2, if_rdata_o=0x2008_0005.
- Store, d_addr_i=0x1001_0000, d_wdata_i=0xDEAD_BEEF -> one-cycle mem_we_o in D_ACC, d_ready_o at N+2, err_o=0.
- Both requests held continuously -> D,D,D,D,IF grant order with MAX_WAIT=4, then the pattern repeats.
- With MEM_ARB_ROM_WP_EN, store to 0x0000_0010 -> mem_we_o stays 0, err_o=1 with d_ready_o; without the macro -> mem_we_o=1, err_o=0.
- Reset asserted in D_ACC -> no d_ready_o, IDLE next cycle, all outputs 0.
- Request pulsed for one cycle while another access is in flight -> never granted, no ready pulse.
